// File: rtl/tpu_pkg.sv
// Shared definitions for the tpuv1 host-side bus initiator: address map,
// driver state encoding and the per-beat address helper.
package tpu_pkg;

  localparam logic [15:0] A_BASE    = 16'h0100;
  localparam logic [15:0] B_BASE    = 16'h0200;
  localparam logic [15:0] C_BASE    = 16'h0300;
  localparam logic [15:0] TRIG_ADDR = 16'h0400;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    LOAD_C,
    TRIGGER,
    WAIT,
    READ_C
  } tpu_state_e;

  // Each bus word occupies 8 bytes of address space.
  function automatic logic [15:0] beat_addr(input logic [15:0] base, input logic [7:0] k);
    return base + {5'b0, k, 3'b000};
  endfunction

endpackage

// File: rtl/tpu_host_driver.sv
// Bus initiator for the tpuv1 slave port: streams A, B and optional C
// words into the array, fires the multiply, waits for the systolic pipe
// to drain, then streams the C result back out.
//
// Handshakes: a word moves on in_* (or out_*) only in a cycle where both
// valid and ready are high at the rising clock edge; valid never depends
// on ready, and the producer holds data stable while valid is high and
// ready is low.
module tpu_host_driver #(
  parameter int DIM      = 8,
  parameter int DATAW    = 64,
  parameter int ADDRW    = 16,
  parameter int WAIT_CYC = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             c_init_en,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic [ADDRW-1:0] tpu_addr,
  output logic             tpu_r_w,
  output logic [DATAW-1:0] tpu_wdata,
  input  logic [DATAW-1:0] tpu_rdata
);
  import tpu_pkg::*;

  localparam int KW = $clog2(2 * DIM);
  localparam int WW = $clog2(WAIT_CYC + 1);
  localparam logic [KW-1:0] K_AB_LAST = KW'(DIM - 1);
  localparam logic [KW-1:0] K_C_LAST  = KW'(2 * DIM - 1);

  tpu_state_e       state, state_n;
  logic [KW-1:0]    k, k_n;
  logic [WW-1:0]    wcnt, wcnt_n;
  logic             cinit, cinit_n;
  logic [ADDRW-1:0] addr_n;
  logic             rw_n;
  logic [DATAW-1:0] wdata_n;
  logic             busy_n, done_n, ovalid_n;
  logic [15:0]      load_base;
  logic [KW-1:0]    k_last;

  assign in_ready = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_C);
  // tpuv1 read data is combinational in the address, so it is forwarded directly.
  assign out_data = tpu_rdata;

  // State, counters and all registered bus/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      wcnt      <= '0;
      cinit     <= 1'b0;
      tpu_addr  <= '0;
      tpu_r_w   <= 1'b0;
      tpu_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      wcnt      <= wcnt_n;
      cinit     <= cinit_n;
      tpu_addr  <= addr_n;
      tpu_r_w   <= rw_n;
      tpu_wdata <= wdata_n;
      busy      <= busy_n;
      done      <= done_n;
      out_valid <= ovalid_n;
    end
  end

  // Next-state and next bus cycle; the bus defaults to idle (addr 0, read).
  always_comb begin
    state_n   = state;
    k_n       = k;
    wcnt_n    = wcnt;
    cinit_n   = cinit;
    addr_n    = '0;
    rw_n      = 1'b0;
    wdata_n   = '0;
    busy_n    = busy;
    done_n    = 1'b0;
    ovalid_n  = 1'b0;
    load_base = A_BASE;
    k_last    = K_AB_LAST;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = LOAD_A;
          k_n     = '0;
          cinit_n = c_init_en;
          busy_n  = 1'b1;
        end
      end

      LOAD_A, LOAD_B, LOAD_C: begin
        if (state == LOAD_B) load_base = B_BASE;
        if (state == LOAD_C) begin
          load_base = C_BASE;
          k_last    = K_C_LAST;
        end
        if (in_valid && in_ready) begin
          rw_n    = 1'b1;
          wdata_n = in_data;
          addr_n  = ADDRW'(beat_addr(load_base, 8'(k)));
          if (k == k_last) begin
            k_n = '0;
            case (state)
              LOAD_A:  state_n = LOAD_B;
              LOAD_B:  state_n = cinit ? LOAD_C : TRIGGER;
              default: state_n = TRIGGER;
            endcase
          end else begin
            k_n = k + KW'(1);
          end
        end
      end

      // Entered one cycle after the last load write, so the two never overlap.
      TRIGGER: begin
        rw_n    = 1'b1;
        addr_n  = ADDRW'(TRIG_ADDR);
        wcnt_n  = WW'(WAIT_CYC - 1);
        state_n = WAIT;
      end

      WAIT: begin
        if (wcnt == '0) begin
          state_n  = READ_C;
          k_n      = '0;
          addr_n   = ADDRW'(C_BASE);
          ovalid_n = 1'b1;
        end else begin
          wcnt_n = wcnt - WW'(1);
        end
      end

      READ_C: begin
        addr_n = tpu_addr;
        if (out_valid && out_ready) begin
          if (k == K_C_LAST) begin
            state_n = IDLE;
            k_n     = '0;
            addr_n  = '0;
            done_n  = 1'b1;
            busy_n  = 1'b0;
          end else begin
            // valid drops for the cycle in which the new address settles.
            k_n    = k + KW'(1);
            addr_n = ADDRW'(beat_addr(C_BASE, 8'(k) + 8'd1));
          end
        end else begin
          ovalid_n = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tpu_host_driver.sv
// Bench for tpu_host_driver with a behavioural tpuv1 slave and a matrix-level
// reference model of the job results.
module tb_tpu_host_driver;
  localparam int DIM      = 8;
  localparam int DATAW    = 64;
  localparam int ADDRW    = 16;
  localparam int WAIT_CYC = 24;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start = 1'b0;
  logic             c_init_en = 1'b0;
  logic             busy, done;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DATAW-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DATAW-1:0] out_data;
  logic [ADDRW-1:0] tpu_addr;
  logic             tpu_r_w;
  logic [DATAW-1:0] tpu_wdata;
  logic [DATAW-1:0] tpu_rdata;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  tpu_host_driver #(.DIM(DIM), .DATAW(DATAW), .ADDRW(ADDRW), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .c_init_en(c_init_en),
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tpu_addr(tpu_addr), .tpu_r_w(tpu_r_w), .tpu_wdata(tpu_wdata), .tpu_rdata(tpu_rdata)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- tpuv1 slave model ----------------
  logic [63:0] a_mem[8]  = '{default: '0};
  logic [63:0] b_mem[8]  = '{default: '0};
  logic [63:0] c_mem[16] = '{default: '0};

  assign tpu_rdata = (tpu_addr >= 16'h0300 && tpu_addr < 16'h0380) ? c_mem[tpu_addr[6:3]] : 64'h0;

  always @(posedge clk) begin
    logic signed [15:0] acc;
    logic signed [7:0]  ea, eb;
    if (tpu_r_w) begin
      case (tpu_addr[15:8])
        8'h01: a_mem[tpu_addr[5:3]] <= tpu_wdata;
        8'h02: b_mem[tpu_addr[5:3]] <= tpu_wdata;
        8'h03: c_mem[tpu_addr[6:3]] <= tpu_wdata;
        8'h04: begin
          for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
              acc = c_mem[i*2 + j/4][(j%4)*16 +: 16];
              for (int m = 0; m < 8; m++) begin
                ea  = a_mem[i][m*8 +: 8];
                eb  = b_mem[m][j*8 +: 8];
                acc = acc + ea * eb;
              end
              c_mem[i*2 + j/4][(j%4)*16 +: 16] <= acc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- bus / handshake monitor ----------------
  logic [15:0] log_addr[$];
  logic [63:0] log_data[$];
  int          log_cyc[$];
  int          beat_cnt = 0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (tpu_r_w) begin
      log_addr.push_back(tpu_addr);
      log_data.push_back(tpu_wdata);
      log_cyc.push_back(cyc);
    end
    if (in_valid && in_ready) beat_cnt <= beat_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // ---------------- reference model (matrix level) ----------------
  int ra[8][8];
  int rb[8][8];
  int rc[8][8];

  task automatic ref_job(input logic [63:0] words[$], input bit cinit);
    int sum;
    logic [15:0] t16;
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) begin
        ra[r][j] = int'($signed(words[r][j*8 +: 8]));
        rb[r][j] = int'($signed(words[8 + r][j*8 +: 8]));
      end
    if (cinit)
      for (int w = 0; w < 16; w++)
        for (int j = 0; j < 4; j++)
          rc[w/2][(w%2)*4 + j] = int'($signed(words[16 + w][j*16 +: 16]));
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        sum = rc[i][j];
        for (int m = 0; m < 8; m++) sum += ra[i][m] * rb[m][j];
        t16 = sum[15:0];
        rc[i][j] = int'($signed(t16));
      end
  endtask

  function automatic logic [63:0] exp_word(input int w);
    logic [63:0] v;
    for (int j = 0; j < 4; j++) v[j*16 +: 16] = 16'(rc[w/2][(w%2)*4 + j]);
    return v;
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input bit cinit);
    @(posedge clk); #1;
    start = 1'b1;
    c_init_en = cinit;
    @(posedge clk); #1;
    start = 1'b0;
    c_init_en = 1'b0;
  endtask

  task automatic feed(input logic [63:0] words[$], input int first, input int cnt, input int gap);
    int guard;
    for (int i = first; i < first + cnt; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (!in_ready && guard < 50);
      if (!in_ready) check("in_ready_timeout", 1'b0, 1'b1);
      @(posedge clk); #1;
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_job(input int id, input bit cinit, input int gap, input bit stall,
                         input logic [63:0] words[$]);
    logic [63:0] exp_q[$];
    int w0, b0, d0, n, nw, rd_cyc, guard, got_n, stall_left, breaks, c_writes;
    bit found, prev_hs;
    logic [15:0] ea;
    logic [63:0] ed;
    w0 = log_addr.size();
    b0 = beat_cnt;
    d0 = done_cnt;
    n  = words.size();
    ref_job(words, cinit);
    for (int w = 0; w < 16; w++) exp_q.push_back(exp_word(w));

    pulse_start(cinit);
    check($sformatf("job%0d_busy_after_start", id), busy, 1'b1);
    feed(words, 0, n, gap);

    found = 0;
    rd_cyc = 0;
    for (int t = 0; t < 300 && !found; t++) begin
      @(negedge clk);
      if (!tpu_r_w && tpu_addr == 16'h0300 && out_valid) begin
        found = 1;
        rd_cyc = cyc;
      end
    end
    check($sformatf("job%0d_first_read_seen", id), found, 1'b1);

    nw = log_addr.size() - w0;
    check($sformatf("job%0d_write_count", id), 64'(nw), 64'(n + 1));
    check($sformatf("job%0d_beats", id), 64'(beat_cnt - b0), 64'(n));
    c_writes = 0;
    for (int i = 0; i < nw; i++)
      if (log_addr[w0 + i] >= 16'h0300 && log_addr[w0 + i] < 16'h0380) c_writes++;
    check($sformatf("job%0d_c_writes", id), 64'(c_writes), cinit ? 64'd16 : 64'd0);
    for (int i = 0; i < nw && i < n + 1; i++) begin
      if (i < 8)       ea = 16'h0100 + 16'(8 * i);
      else if (i < 16) ea = 16'h0200 + 16'(8 * (i - 8));
      else if (i < n)  ea = 16'h0300 + 16'(8 * (i - 16));
      else             ea = 16'h0400;
      ed = (i < n) ? words[i] : 64'h0;
      check($sformatf("job%0d_wr_addr[%0d]", id, i), log_addr[w0 + i], ea);
      check($sformatf("job%0d_wr_data[%0d]", id, i), log_data[w0 + i], ed);
    end
    if (nw >= n + 1) begin
      check($sformatf("job%0d_trig_follows_last", id),
            64'(log_cyc[w0 + n] - log_cyc[w0 + n - 1]), 64'd1);
      check($sformatf("job%0d_wait_cycles", id), 64'(rd_cyc - log_cyc[w0 + n]), 64'(WAIT_CYC));
      if (gap == 0) begin
        breaks = 0;
        for (int i = 1; i < n; i++)
          if (log_cyc[w0 + i] - log_cyc[w0 + i - 1] != 1) breaks++;
        check($sformatf("job%0d_back_to_back", id), 64'(breaks), 64'd0);
      end
    end

    got_n = 0;
    guard = 0;
    prev_hs = 0;
    stall_left = stall ? 5 : 0;
    while (got_n < 16 && guard < 400) begin
      @(posedge clk); #1;
      guard++;
      if (prev_hs) begin
        check($sformatf("job%0d_read_gap[%0d]", id, got_n), out_valid, 1'b0);
        prev_hs = 0;
        out_ready = 1'b0;
      end else if (out_valid) begin
        if (stall && got_n == 3 && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          check($sformatf("job%0d_stall_addr", id), tpu_addr, 16'h0318);
          check($sformatf("job%0d_stall_data", id), out_data, exp_q[3]);
        end else begin
          out_ready = 1'b1;
          check($sformatf("job%0d_rd_addr[%0d]", id, got_n), tpu_addr, 16'h0300 + 16'(8 * got_n));
          check($sformatf("job%0d_rd_data[%0d]", id, got_n), out_data, exp_q[got_n]);
          got_n++;
          prev_hs = 1;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
    check($sformatf("job%0d_read_complete", id), 64'(got_n), 64'd16);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("job%0d_done", id), done, 1'b1);
    check($sformatf("job%0d_busy_fall", id), busy, 1'b0);
    check($sformatf("job%0d_addr_idle", id), tpu_addr, 16'h0000);
    @(posedge clk); #1;
    check($sformatf("job%0d_done_once", id), 64'(done_cnt - d0), 64'd1);
    check($sformatf("job%0d_done_low", id), done, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_tpu_addr"}, tpu_addr, 16'h0000);
    check({tag, "_tpu_r_w"}, tpu_r_w, 1'b0);
    check({tag, "_tpu_wdata"}, tpu_wdata, 64'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] words[$];
    int w0, trig;
    logic signed [7:0] bv;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    // Idle: in_valid without a job must not be accepted or cause bus traffic.
    w0 = log_addr.size();
    in_valid = 1'b1;
    in_data  = 64'hDEAD_BEEF_0000_0001;
    repeat (20) @(posedge clk);
    #1;
    check("idle_no_writes", 64'(log_addr.size() - w0), 64'd0);
    check("idle_no_beats", 64'(beat_cnt), 64'd0);
    check_idle_outputs("idle");
    in_valid = 1'b0;

    // Job 1: C loaded, in_valid held, low byte numbers the word.
    words.delete();
    for (int i = 0; i < 32; i++) words.push_back({$urandom(), 24'($urandom()), 8'(i)});
    run_job(1, 1'b1, 0, 1'b0, words);

    // Job 2: accumulate (no C load), gapped input.
    words.delete();
    for (int i = 0; i < 16; i++) words.push_back({$urandom(), $urandom()});
    run_job(2, 1'b0, 2, 1'b0, words);

    // Job 3: C loaded, consumer stalls on word 3.
    words.delete();
    for (int i = 0; i < 32; i++) words.push_back({$urandom(), $urandom()});
    run_job(3, 1'b1, 0, 1'b1, words);

    // Reset in the middle of LOAD_B: job abandoned, no trigger.
    words.delete();
    for (int i = 0; i < 32; i++) words.push_back({$urandom(), $urandom()});
    w0 = log_addr.size();
    pulse_start(1'b1);
    feed(words, 0, 8 + int'($urandom_range(1, 6)), 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 check_idle_outputs("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    trig = 0;
    for (int i = w0; i < log_addr.size(); i++) if (log_addr[i] == 16'h0400) trig++;
    check("midreset_no_trigger", 64'(trig), 64'd0);
    check("midreset_busy", busy, 1'b0);

    // Job 4: A = I, B rows of signed values, C = 0 -> readback is B sign-extended.
    words.delete();
    for (int r = 0; r < 8; r++) begin
      logic [63:0] row = '0;
      row[r*8 +: 8] = 8'd1;
      words.push_back(row);
    end
    for (int r = 0; r < 8; r++) begin
      logic [63:0] row = '0;
      for (int j = 0; j < 8; j++) begin
        bv = 8'(r * 20 - 70 + j);
        row[j*8 +: 8] = bv;
      end
      words.push_back(row);
    end
    for (int i = 0; i < 16; i++) words.push_back(64'h0);
    run_job(4, 1'b1, 0, 1'b0, words);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
